// File: rtl/map_feed_pkg.sv
// Shared types and helpers for the constellation-mapper front end.
// Modulation encodings, FSM states and the bits-per-symbol lookup.
`timescale 1ns/1ps
package map_feed_pkg;

   localparam int LANES  = 8;
   localparam int LANE_W = 8;

   typedef enum logic [2:0] {
      MOD_BPSK   = 3'd0,
      MOD_QPSK   = 3'd1,
      MOD_QAM16  = 3'd2,
      MOD_QAM64  = 3'd3,
      MOD_QAM256 = 3'd4
   } mod_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_ISSUE
   } state_e;

   function automatic logic [3:0] bps_of(input mod_e m);
      case (m)
         MOD_QPSK:   bps_of = 4'd2;
         MOD_QAM16:  bps_of = 4'd4;
         MOD_QAM64:  bps_of = 4'd6;
         MOD_QAM256: bps_of = 4'd8;
         default:    bps_of = 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/map_lane_unpack.sv
// Splits a packed bit accumulator into eight mapper lanes of bps bits each,
// zero-extended to a byte per lane.
`timescale 1ns/1ps
module map_lane_unpack
   import map_feed_pkg::*;
(
   input  logic [63:0] i_acc,
   input  logic [3:0]  i_bps,
   output logic [63:0] o_mapData
);

   logic [7:0] w_mask;

   // bps is always 1..8, so the shift never exceeds 7
   assign w_mask = 8'hFF >> (4'd8 - i_bps);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign o_mapData[k*LANE_W +: LANE_W] = LANE_W'(i_acc >> (k * i_bps)) & w_mask;
   end

endmodule

// File: rtl/map_feed_ctrl.sv
// Byte-stream sequencer feeding the 8-lane constellation mapper.
// Optional statistics outputs are built when MAP_FEED_STATS_EN is defined.
`timescale 1ns/1ps
module map_feed_ctrl
   import map_feed_pkg::*;
#(
   parameter int MAP_LATENCY = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  cfg_mod,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        m_ready,
   output logic        map_en,
   output logic [63:0] map_data,
   output logic        m_valid,
   output logic        m_last,
   output logic        cfg_err,
`ifdef MAP_FEED_STATS_EN
   output logic [31:0] stat_groups,
   output logic [15:0] stat_pad_bytes,
`endif
   output logic        busy
);

   state_e                 r_state;
   mod_e                   r_mod;
   logic [63:0]            r_acc;
   logic [3:0]             r_cnt;
   logic                   r_last;
   logic [63:0]            r_mapData;
   logic [MAP_LATENCY-1:0] r_pipeV;
   logic [MAP_LATENCY-1:0] r_pipeL;

   state_e      w_nextState;
   mod_e        w_inMod;
   mod_e        w_modNext;
   logic [63:0] w_accNext;
   logic [3:0]  w_cntNext;
   logic [3:0]  w_bpsNext;
   logic [3:0]  w_bpsQ;
   logic        w_lastNext;
   logic        w_accept;
   logic        w_mapEn;
   logic [63:0] w_unpacked;

   assign w_inMod  = (cfg_mod > 3'd4) ? MOD_BPSK : mod_e'(cfg_mod);
   assign w_bpsQ   = bps_of(r_mod);
   assign s_ready  = (r_state != ST_ISSUE);
   assign w_accept = s_valid && s_ready;
   assign w_mapEn  = (r_state == ST_ISSUE) && m_ready;

   // Next-state view of the accumulator so map_data can be registered on ISSUE entry
   always_comb begin
      w_nextState = r_state;
      w_modNext   = r_mod;
      w_accNext   = r_acc;
      w_cntNext   = r_cnt;
      w_bpsNext   = w_bpsQ;
      w_lastNext  = r_last;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_modNext   = w_inMod;
               w_bpsNext   = bps_of(w_inMod);
               w_accNext   = {56'd0, s_data};
               w_cntNext   = 4'd1;
               w_lastNext  = s_last;
               w_nextState = (bps_of(w_inMod) == 4'd1 || s_last) ? ST_ISSUE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (w_accept) begin
               w_accNext[8*r_cnt +: 8] = s_data;
               w_cntNext   = r_cnt + 4'd1;
               w_lastNext  = s_last;
               if ((r_cnt + 4'd1 == w_bpsQ) || s_last) w_nextState = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (m_ready) begin
               w_accNext   = '0;
               w_cntNext   = 4'd0;
               w_nextState = r_last ? ST_IDLE : ST_FILL;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   map_lane_unpack u_unpack (
      .i_acc     (w_accNext),
      .i_bps     (w_bpsNext),
      .o_mapData (w_unpacked)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_mod     <= MOD_BPSK;
         r_acc     <= '0;
         r_cnt     <= 4'd0;
         r_last    <= 1'b0;
         r_mapData <= '0;
         r_pipeV   <= '0;
         r_pipeL   <= '0;
      end else begin
         r_state <= w_nextState;
         r_mod   <= w_modNext;
         r_acc   <= w_accNext;
         r_cnt   <= w_cntNext;
         r_last  <= w_lastNext;
         if (r_state != ST_ISSUE && w_nextState == ST_ISSUE)
            r_mapData <= w_unpacked;
         else if (w_mapEn && r_last)
            r_mapData <= '0;
         r_pipeV <= (r_pipeV << 1) | MAP_LATENCY'(w_mapEn);
         r_pipeL <= (r_pipeL << 1) | MAP_LATENCY'(w_mapEn && r_last);
      end
   end

`ifdef MAP_FEED_STATS_EN
   logic [31:0] r_statGroups;
   logic [15:0] r_statPad;
   logic [16:0] w_padSum;

   // Short final groups leave (bps - bytes received) zero bytes in the lane word
   assign w_padSum = {1'b0, r_statPad} + {13'd0, (w_bpsQ - r_cnt)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_statGroups <= '0;
         r_statPad    <= '0;
      end else if (w_mapEn) begin
         r_statGroups <= r_statGroups + 32'd1;
         r_statPad    <= w_padSum[16] ? 16'hFFFF : w_padSum[15:0];
      end
   end

   assign stat_groups    = r_statGroups;
   assign stat_pad_bytes = r_statPad;
`endif

   assign map_en   = w_mapEn;
   assign map_data = r_mapData;
   assign m_valid  = r_pipeV[MAP_LATENCY-1];
   assign m_last   = r_pipeV[MAP_LATENCY-1] & r_pipeL[MAP_LATENCY-1];
   assign cfg_err  = (r_state == ST_IDLE) && w_accept && (cfg_mod > 3'd4);
   assign busy     = (r_state != ST_IDLE) || (|r_pipeV);

endmodule

// File: tb/tb_map_feed_ctrl.sv
// Directed scoreboard bench for map_feed_ctrl (stats checked when MAP_FEED_STATS_EN is defined).
`timescale 1ns/1ps
module tb_map_feed_ctrl;

   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  cfg_mod;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic        m_ready;
   logic        map_en;
   logic [63:0] map_data;
   logic        m_valid;
   logic        m_last;
   logic        cfg_err;
   logic        busy;
`ifdef MAP_FEED_STATS_EN
   logic [31:0] stat_groups;
   logic [15:0] stat_pad_bytes;
`endif

   map_feed_ctrl #(.MAP_LATENCY(LAT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_mod  (cfg_mod),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_ready  (m_ready),
      .map_en   (map_en),
      .map_data (map_data),
      .m_valid  (m_valid),
      .m_last   (m_last),
      .cfg_err  (cfg_err),
`ifdef MAP_FEED_STATS_EN
      .stat_groups    (stat_groups),
      .stat_pad_bytes (stat_pad_bytes),
`endif
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } grp_t;

   typedef struct {
      int   due;
      logic last;
   } pipe_t;

   grp_t  mapQ[$];
   pipe_t pipeQ[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int errPulses = 0;
   int padExp = 0;
   int groupsExp = 0;
   logic [7:0] fb[16];

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int bpsModel(input int m);
      case (m)
         1: return 2;
         2: return 4;
         3: return 6;
         4: return 8;
         default: return 1;
      endcase
   endfunction

   function automatic logic [63:0] packModel(input logic [63:0] acc, input int bps);
      logic [63:0] res;
      logic [63:0] lane;
      res = '0;
      for (int k = 0; k < 8; k++) begin
         lane = (acc >> (k * bps)) & ((64'd1 << bps) - 64'd1);
         res[k*8 +: 8] = lane[7:0];
      end
      return res;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pairs every map_en with a queued group and every m_valid with its due cycle
   grp_t mg;
   logic expV;
   always @(negedge clk) begin
      if (rst_n) begin
         expV = (pipeQ.size() > 0) && (pipeQ[0].due == cyc);
         checkVal("m_valid", m_valid, expV);
         if (expV) begin
            checkVal("m_last", m_last, pipeQ[0].last);
            void'(pipeQ.pop_front());
         end
         if (map_en) begin
            if (mapQ.size() == 0) begin
               checkVal("map_en_unexpected", map_en, 0);
            end else begin
               mg = mapQ.pop_front();
               checkVal("map_data", map_data, mg.data);
               pipeQ.push_back('{cyc + LAT, mg.last});
            end
         end
         if (cfg_err) errPulses++;
      end
   end

   task automatic applyStimulus(input logic [7:0] d, input logic l, input int m);
      int n;
      s_data  = d;
      s_last  = l;
      cfg_mod = 3'(m);
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) checkVal("s_ready_timeout", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic sendFrame(input int n, input int mod0, input int modLater,
                            input bit useLit, input logic [63:0] lit);
      int bps;
      int cnt;
      bit first;
      logic [63:0] acc;
      grp_t g;
      bps = bpsModel(mod0);
      cnt = 0;
      first = 1'b1;
      acc = '0;
      for (int i = 0; i < n; i++) begin
         acc[8*cnt +: 8] = fb[i];
         cnt++;
         if (cnt == bps || i == n - 1) begin
            g.data = (useLit && first) ? lit : packModel(acc, bps);
            g.last = (i == n - 1);
            mapQ.push_back(g);
            padExp += bps - cnt;
            groupsExp++;
            first = 1'b0;
            acc = '0;
            cnt = 0;
         end
         applyStimulus(fb[i], i == n - 1, (i == 0) ? mod0 : modLater);
      end
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checkVal(tag, busy, 0);
      checkVal({tag, "_map_data"}, map_data, 0);
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, "_s_ready"}, s_ready, 1);
      checkVal({tag, "_map_en"}, map_en, 0);
      checkVal({tag, "_map_data"}, map_data, 0);
      checkVal({tag, "_m_valid"}, m_valid, 0);
      checkVal({tag, "_m_last"}, m_last, 0);
      checkVal({tag, "_cfg_err"}, cfg_err, 0);
      checkVal({tag, "_busy"}, busy, 0);
`ifdef MAP_FEED_STATS_EN
      checkVal({tag, "_stat_groups"}, stat_groups, 0);
      checkVal({tag, "_stat_pad"}, stat_pad_bytes, 0);
`endif
   endtask

   logic [63:0] expStall;
   int errBefore;
   grp_t rg;

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
      cfg_mod = 3'd0;
      m_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] BPSK single byte");
      fb[0] = 8'hA5;
      sendFrame(1, 0, 0, 1'b1, 64'h0100010000010001);
      waitIdle("bpsk_idle");

      $display("[TB] QAM16 one group");
      fb[0] = 8'h21; fb[1] = 8'h43; fb[2] = 8'h65; fb[3] = 8'h87;
      sendFrame(4, 2, 2, 1'b1, 64'h0807060504030201);
      waitIdle("qam16_idle");

      $display("[TB] QAM64 short padded group");
      fb[0] = 8'hFF; fb[1] = 8'hFF;
      sendFrame(2, 3, 3, 1'b1, 64'h00000000000F3F3F);
      waitIdle("qam64_idle");
`ifdef MAP_FEED_STATS_EN
      checkVal("stat_pad_qam64", stat_pad_bytes, 4);
`endif

      $display("[TB] stall in ISSUE");
      m_ready = 1'b0;
      fb[0] = 8'h10; fb[1] = 8'h32; fb[2] = 8'h54; fb[3] = 8'h76;
      expStall = 64'h0706050403020100;
      sendFrame(4, 2, 2, 1'b1, expStall);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkVal("stall_map_en", map_en, 0);
         checkVal("stall_s_ready", s_ready, 0);
         checkVal("stall_map_data", map_data, expStall);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(negedge clk);
      checkVal("stall_release_map_en", map_en, 1);
      waitIdle("stall_idle");

      $display("[TB] cfg_mod change mid-frame");
      fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
      sendFrame(4, 1, 4, 1'b0, '0);
      waitIdle("qpsk_idle");
      for (int i = 0; i < 8; i++) fb[i] = 8'(8'h9C + i * 8'h13);
      sendFrame(8, 4, 4, 1'b0, '0);
      waitIdle("qam256_idle");

      $display("[TB] invalid cfg_mod");
      errBefore = errPulses;
      fb[0] = 8'h3C;
      sendFrame(1, 7, 7, 1'b0, '0);
      waitIdle("cfgerr_idle");
      checkVal("cfg_err_pulse", errPulses - errBefore, 1);
`ifdef MAP_FEED_STATS_EN
      checkVal("stat_groups", stat_groups, groupsExp);
      checkVal("stat_pad_total", stat_pad_bytes, padExp);
`endif

      $display("[TB] reset mid-FILL with groups in pipe");
      cfg_mod = 3'd1;
      rg.last = 1'b0;
      rg.data = packModel(64'h0201, 2);
      mapQ.push_back(rg);
      applyStimulus(8'h01, 1'b0, 1);
      applyStimulus(8'h02, 1'b0, 1);
      rg.data = packModel(64'h0403, 2);
      mapQ.push_back(rg);
      applyStimulus(8'h03, 1'b0, 1);
      applyStimulus(8'h04, 1'b0, 1);
      applyStimulus(8'h05, 1'b0, 1);
      checkVal("pre_reset_pipe_depth", pipeQ.size(), 2);
      rst_n = 1'b0;
      mapQ.delete();
      pipeQ.delete();
      @(negedge clk);
      checkOutput("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (LAT + 8) @(posedge clk);
      #1;
      checkVal("post_reset_busy", busy, 0);

      checkVal("mapQ_drained", mapQ.size(), 0);
      checkVal("pipeQ_drained", pipeQ.size(), 0);
      checkVal("cfg_err_total", errPulses, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
